sreg_master: RTL and testbench

SREG_MASTER -- requirements
Module: sreg_master

---
 rtl/sreg_master_pkg.sv | 50 +++++
 rtl/sreg_master_chan_hold.sv | 62 ++++++
 rtl/sreg_master.sv | 240 ++++++++++++++++++++++++
 tb/tb_sreg_master.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sreg_master_pkg.sv
// -----------------------------------------------------------------------------
// sreg_master_pkg
// Shared definitions for the AXI4-Lite to SREG bridge:
//   - bus widths used by the bridge and its channel holding registers
//   - FSM state encoding of the bridge sequencer
//   - AXI response codes
//   - SREG register byte offsets of the downstream register block
//   - small helpers used by the sequencer
// -----------------------------------------------------------------------------
package sreg_master_pkg;

  localparam int ADDR_W = 18;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_ISSUE = 3'd1,
    WR_RESP  = 3'd2,
    RD_ISSUE = 3'd3,
    RD_WAIT  = 3'd4,
    RD_RESP  = 3'd5
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // SREG register map (byte offsets)
  localparam logic [ADDR_W-1:0] SREG_EN        = 18'h00000;
  localparam logic [ADDR_W-1:0] SREG_IBASE     = 18'h00010;
  localparam logic [ADDR_W-1:0] SREG_ISIZE     = 18'h00014;
  localparam logic [ADDR_W-1:0] SREG_OBASE     = 18'h00018;
  localparam logic [ADDR_W-1:0] SREG_OSIZE     = 18'h0001C;
  localparam logic [ADDR_W-1:0] SREG_FRAME_LEN = 18'h00020;
  localparam logic [ADDR_W-1:0] SREG_FRAME_ADJ = 18'h00024;
  localparam logic [ADDR_W-1:0] SREG_TSTART    = 18'h00030;
  localparam logic [ADDR_W-1:0] SREG_TEND      = 18'h00034;
  localparam logic [ADDR_W-1:0] SREG_RSTART    = 18'h00038;
  localparam logic [ADDR_W-1:0] SREG_REND      = 18'h0003C;

  // The SREG port only supports full-word writes.
  function automatic logic strb_full(input logic [STRB_W-1:0] strb);
    return (strb == {STRB_W{1'b1}});
  endfunction

  function automatic logic [1:0] wr_resp_code(input logic [STRB_W-1:0] strb);
    return strb_full(strb) ? RESP_OKAY : RESP_SLVERR;
  endfunction

endpackage

// File: rtl/sreg_master_chan_hold.sv
// -----------------------------------------------------------------------------
// axil_chan_hold
// Single-entry holding register for one AXI4-Lite request channel.
// The channel is accepted whenever the register is empty; the content stays
// until the consumer pulses clr. The ready output is a flop (not derived from
// any input) so the AXI side sees no combinational path through the bridge.
//
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   in_data   : channel payload
//   in_valid  : channel valid
//   in_ready  : channel ready, high while the holding register is empty
//   full      : holding register contains a payload
//   data      : held payload (meaningful while full)
//   clr       : consumer has finished with the payload; empty the register
// -----------------------------------------------------------------------------
module axil_chan_hold #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              full,
  output logic [DATA_W-1:0] data,
  input  logic              clr
);

  logic take;
  logic full_nxt;

  assign take = in_valid & in_ready;

  // clr and take are mutually exclusive: clr only comes while full,
  // and in_ready is low while full.
  always_comb begin
    full_nxt = full;
    if (clr) begin
      full_nxt = 1'b0;
    end else if (take) begin
      full_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full     <= 1'b0;
      in_ready <= 1'b0;
    end else begin
      full     <= full_nxt;
      in_ready <= ~full_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (take) begin
      data <= in_data;
    end
  end

endmodule

// File: rtl/sreg_master.sv
// -----------------------------------------------------------------------------
// sreg_master
// AXI4-Lite slave that converts single-beat reads/writes into one-cycle
// accesses on a simple SREG strobe interface.
//
// Ports:
//   clk, rst                         : clock, asynchronous active-high reset
//   s_aw* / s_w* / s_b*              : AXI4-Lite write address/data/response
//   s_ar* / s_r*                     : AXI4-Lite read address/data
//   sreg_en                          : one-cycle access strobe
//   sreg_wen                         : 1 = write, 0 = read (held between strobes)
//   sreg_addr                        : byte address (held between strobes)
//   sreg_din                         : write data (held between strobes)
//   sreg_dout                        : read data, valid the cycle after sreg_en
//
// AW, W and AR are each captured by their own holding register, so requests
// can be accepted while another access is in progress. A write needs both AW
// and W held; when a write and a read are both ready in IDLE, a round-robin
// flag decides. Partial-strobe writes are refused with SLVERR and never reach
// the SREG port. Every output comes straight from a flop.
// -----------------------------------------------------------------------------
module sreg_master
  import sreg_master_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [DATA_W-1:0] s_wdata,
  input  logic [STRB_W-1:0] s_wstrb,
  input  logic              s_wvalid,
  output logic              s_wready,
  output logic [1:0]        s_bresp,
  output logic              s_bvalid,
  input  logic              s_bready,
  input  logic [ADDR_W-1:0] s_araddr,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [DATA_W-1:0] s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic              sreg_en,
  output logic              sreg_wen,
  output logic [ADDR_W-1:0] sreg_addr,
  output logic [DATA_W-1:0] sreg_din,
  input  logic [DATA_W-1:0] sreg_dout
);

  logic                     aw_full;
  logic                     w_full;
  logic                     ar_full;
  logic [ADDR_W-1:0]        aw_addr;
  logic [ADDR_W-1:0]        ar_addr;
  logic [STRB_W+DATA_W-1:0] w_bus;
  logic [DATA_W-1:0]        w_data;
  logic [STRB_W-1:0]        w_strb;
  logic                     clr_wr;
  logic                     clr_rd;

  state_e                   state;
  state_e                   state_nxt;
  logic                     prio_wr;
  logic                     prio_nxt;
  logic                     wr_elig;
  logic                     rd_elig;
  logic                     grant_wr;
  logic                     grant_rd;

  logic                     en_nxt;
  logic                     wen_nxt;
  logic [ADDR_W-1:0]        addr_nxt;
  logic [DATA_W-1:0]        din_nxt;
  logic                     bvalid_nxt;
  logic [1:0]               bresp_nxt;
  logic                     rvalid_nxt;
  logic [1:0]               rresp_nxt;
  logic [DATA_W-1:0]        rdata_nxt;

  assign w_data = w_bus[DATA_W-1:0];
  assign w_strb = w_bus[STRB_W+DATA_W-1:DATA_W];

  axil_chan_hold #(.DATA_W(ADDR_W)) u_aw_hold (
    .clk      (clk),
    .rst      (rst),
    .in_data  (s_awaddr),
    .in_valid (s_awvalid),
    .in_ready (s_awready),
    .full     (aw_full),
    .data     (aw_addr),
    .clr      (clr_wr)
  );

  axil_chan_hold #(.DATA_W(STRB_W + DATA_W)) u_w_hold (
    .clk      (clk),
    .rst      (rst),
    .in_data  ({s_wstrb, s_wdata}),
    .in_valid (s_wvalid),
    .in_ready (s_wready),
    .full     (w_full),
    .data     (w_bus),
    .clr      (clr_wr)
  );

  axil_chan_hold #(.DATA_W(ADDR_W)) u_ar_hold (
    .clk      (clk),
    .rst      (rst),
    .in_data  (s_araddr),
    .in_valid (s_arvalid),
    .in_ready (s_arready),
    .full     (ar_full),
    .data     (ar_addr),
    .clr      (clr_rd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      prio_wr <= 1'b1;
    end else begin
      state   <= state_nxt;
      prio_wr <= prio_nxt;
    end
  end

  // Next state plus the next value of every registered output. Outputs
  // default to holding, except sreg_en which is a single-cycle strobe.
  always_comb begin
    state_nxt  = state;
    prio_nxt   = prio_wr;
    wr_elig    = aw_full & w_full;
    rd_elig    = ar_full;
    grant_wr   = 1'b0;
    grant_rd   = 1'b0;
    clr_wr     = 1'b0;
    clr_rd     = 1'b0;
    en_nxt     = 1'b0;
    wen_nxt    = sreg_wen;
    addr_nxt   = sreg_addr;
    din_nxt    = sreg_din;
    bvalid_nxt = s_bvalid;
    bresp_nxt  = s_bresp;
    rvalid_nxt = s_rvalid;
    rresp_nxt  = s_rresp;
    rdata_nxt  = s_rdata;

    unique case (state)
      IDLE: begin
        grant_wr = wr_elig & (~rd_elig | prio_wr);
        grant_rd = rd_elig & ~grant_wr;
        if (grant_wr) begin
          prio_nxt = ~prio_wr;
          if (strb_full(w_strb)) begin
            state_nxt = WR_ISSUE;
            en_nxt    = 1'b1;
            wen_nxt   = 1'b1;
            addr_nxt  = aw_addr;
            din_nxt   = w_data;
          end else begin
            state_nxt  = WR_RESP;
            bvalid_nxt = 1'b1;
            bresp_nxt  = wr_resp_code(w_strb);
          end
        end else if (grant_rd) begin
          prio_nxt  = ~prio_wr;
          state_nxt = RD_ISSUE;
          en_nxt    = 1'b1;
          wen_nxt   = 1'b0;
          addr_nxt  = ar_addr;
        end
      end

      WR_ISSUE: begin
        state_nxt  = WR_RESP;
        bvalid_nxt = 1'b1;
        bresp_nxt  = RESP_OKAY;
      end

      WR_RESP: begin
        if (s_bready) begin
          state_nxt  = IDLE;
          bvalid_nxt = 1'b0;
          clr_wr     = 1'b1;
        end
      end

      RD_ISSUE: begin
        state_nxt = RD_WAIT;
      end

      // sreg_dout is valid during this cycle; capture it at the closing edge.
      RD_WAIT: begin
        state_nxt  = RD_RESP;
        rvalid_nxt = 1'b1;
        rresp_nxt  = RESP_OKAY;
        rdata_nxt  = sreg_dout;
      end

      RD_RESP: begin
        if (s_rready) begin
          state_nxt  = IDLE;
          rvalid_nxt = 1'b0;
          clr_rd     = 1'b1;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output registers; reset clears them immediately, so a strobe in flight
  // is dropped without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg_en   <= 1'b0;
      sreg_wen  <= 1'b0;
      sreg_addr <= '0;
      sreg_din  <= '0;
      s_bvalid  <= 1'b0;
      s_bresp   <= RESP_OKAY;
      s_rvalid  <= 1'b0;
      s_rresp   <= RESP_OKAY;
      s_rdata   <= '0;
    end else begin
      sreg_en   <= en_nxt;
      sreg_wen  <= wen_nxt;
      sreg_addr <= addr_nxt;
      sreg_din  <= din_nxt;
      s_bvalid  <= bvalid_nxt;
      s_bresp   <= bresp_nxt;
      s_rvalid  <= rvalid_nxt;
      s_rresp   <= rresp_nxt;
      s_rdata   <= rdata_nxt;
    end
  end

endmodule

// File: tb/tb_sreg_master.sv
// -----------------------------------------------------------------------------
// tb_sreg_master
// Bench for sreg_master: an SREG slave model answers the strobe port, and
// expected SREG cycles, write responses and read responses are queued when
// stimulus is issued and popped by a monitor as the DUT produces them.
// -----------------------------------------------------------------------------
module tb_sreg_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [17:0] s_awaddr = '0;
  logic        s_awvalid = 1'b0;
  logic        s_awready;
  logic [31:0] s_wdata = '0;
  logic [3:0]  s_wstrb = '0;
  logic        s_wvalid = 1'b0;
  logic        s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready = 1'b1;
  logic [17:0] s_araddr = '0;
  logic        s_arvalid = 1'b0;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready = 1'b1;
  logic        sreg_en;
  logic        sreg_wen;
  logic [17:0] sreg_addr;
  logic [31:0] sreg_din;
  logic [31:0] sreg_dout = '0;

  sreg_master dut (
    .clk       (clk),
    .rst       (rst),
    .s_awaddr  (s_awaddr),
    .s_awvalid (s_awvalid),
    .s_awready (s_awready),
    .s_wdata   (s_wdata),
    .s_wstrb   (s_wstrb),
    .s_wvalid  (s_wvalid),
    .s_wready  (s_wready),
    .s_bresp   (s_bresp),
    .s_bvalid  (s_bvalid),
    .s_bready  (s_bready),
    .s_araddr  (s_araddr),
    .s_arvalid (s_arvalid),
    .s_arready (s_arready),
    .s_rdata   (s_rdata),
    .s_rresp   (s_rresp),
    .s_rvalid  (s_rvalid),
    .s_rready  (s_rready),
    .sreg_en   (sreg_en),
    .sreg_wen  (sreg_wen),
    .sreg_addr (sreg_addr),
    .sreg_din  (sreg_din),
    .sreg_dout (sreg_dout)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // SREG slave: 64 words; unwritten words read a fixed address pattern,
  // with 0x14 preset to 0x12345678.
  logic [31:0] mem [0:63];
  logic [63:0] wr_mask = '0;

  function automatic logic [31:0] dflt_word(input logic [17:0] a);
    return (a[7:2] == 6'd5) ? 32'h1234_5678 : (32'hA500_0000 | {24'b0, a[7:2], 2'b00});
  endfunction

  always @(posedge clk) begin
    if (sreg_en) begin
      if (sreg_wen) begin
        mem[sreg_addr[7:2]]     <= sreg_din;
        wr_mask[sreg_addr[7:2]] <= 1'b1;
      end else begin
        sreg_dout <= wr_mask[sreg_addr[7:2]] ? mem[sreg_addr[7:2]] : dflt_word(sreg_addr);
      end
    end
  end

  // Scoreboard queues
  typedef struct packed {
    logic        wen;
    logic [17:0] addr;
    logic [31:0] din;
  } sreg_t;

  sreg_t       q_sreg[$];
  logic [1:0]  q_b[$];
  logic [33:0] q_r[$];

  task automatic exp_wr(input logic [17:0] a, input logic [31:0] d, input logic [3:0] strb);
    if (strb == 4'hF) q_sreg.push_back('{wen: 1'b1, addr: a, din: d});
    q_b.push_back((strb == 4'hF) ? 2'b00 : 2'b10);
  endtask

  task automatic exp_rd(input logic [17:0] a, input logic [31:0] d, input bit with_resp);
    q_sreg.push_back('{wen: 1'b0, addr: a, din: 32'h0});
    if (with_resp) q_r.push_back({2'b00, d});
  endtask

  // Monitor at the falling edge, away from the DUT's active edge.
  logic prev_en = 1'b0;
  always @(negedge clk) begin
    if (sreg_en) begin
      check("sreg_back_to_back", prev_en, 0);
      check("sreg_expected", q_sreg.size() != 0, 1);
      if (q_sreg.size() != 0) begin
        check("sreg_wen", sreg_wen, q_sreg[0].wen);
        check("sreg_addr", sreg_addr, q_sreg[0].addr);
        if (q_sreg[0].wen) check("sreg_din", sreg_din, q_sreg[0].din);
        void'(q_sreg.pop_front());
      end
    end
    prev_en <= sreg_en;
    if (s_bvalid && s_bready) begin
      check("b_expected", q_b.size() != 0, 1);
      if (q_b.size() != 0) check("bresp", s_bresp, q_b.pop_front());
    end
    if (s_rvalid && s_rready) begin
      check("r_expected", q_r.size() != 0, 1);
      if (q_r.size() != 0) check("rresp_rdata", {s_rresp, s_rdata}, q_r.pop_front());
    end
  end

  task automatic drive_write(input logic [17:0] a, input logic [31:0] d, input logic [3:0] strb,
                             input bit meas, input int lat_exp);
    int  n;
    int  lat;
    bit  aw_go;
    bit  w_go;
    @(negedge clk);
    s_awaddr = a; s_awvalid = 1'b1;
    s_wdata = d; s_wstrb = strb; s_wvalid = 1'b1;
    n = 0;
    while ((s_awvalid || s_wvalid) && n < 50) begin
      aw_go = s_awvalid && s_awready;
      w_go  = s_wvalid && s_wready;
      @(posedge clk); #1;
      if (aw_go) s_awvalid = 1'b0;
      if (w_go)  s_wvalid = 1'b0;
      n++;
      if (s_awvalid || s_wvalid) @(negedge clk);
    end
    check("aw_w_handshake", {s_awvalid, s_wvalid}, 0);
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    if (meas) begin
      lat = 0;
      do begin
        @(posedge clk); #1;
        lat++;
      end while (!s_bvalid && lat < 20);
      check("bvalid_latency", lat, lat_exp);
    end
  endtask

  task automatic drive_read(input logic [17:0] a, input bit meas);
    int n;
    int lat;
    @(negedge clk);
    s_araddr = a; s_arvalid = 1'b1;
    n = 0;
    while (!s_arready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ar_handshake_wait", n < 50, 1);
    @(posedge clk); #1;
    s_arvalid = 1'b0;
    if (meas) begin
      lat = 0;
      do begin
        @(posedge clk); #1;
        lat++;
        if (lat == 1) check("rd_issue_cycle1", {sreg_en, sreg_wen}, 2'b10);
      end while (!s_rvalid && lat < 20);
      check("rvalid_latency", lat, 3);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q_sreg.size() != 0 || q_b.size() != 0 || q_r.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_time", n < 200, 1);
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [63:0] all_outs();
    return {s_awready, s_wready, s_arready, s_bvalid, s_bresp, s_rvalid, s_rresp,
            sreg_en, sreg_wen, sreg_addr, sreg_din[0], (s_rdata != 0), (sreg_din != 0)};
  endfunction

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_rst", {s_awready, s_wready, s_arready}, 3'b111);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", all_outs(), 0);
    release_reset();

    // Full write, latency 2 from the W/AW handshake
    exp_wr(18'h00020, 32'h0000_00F0, 4'hF);
    drive_write(18'h00020, 32'h0000_00F0, 4'hF, 1'b1, 2);
    wait_idle();

    // Read with preset slave data, latency 3
    exp_rd(18'h00014, 32'h1234_5678, 1'b1);
    drive_read(18'h00014, 1'b1);
    wait_idle();

    // Read back the word written above
    exp_rd(18'h00020, 32'h0000_00F0, 1'b1);
    drive_read(18'h00020, 1'b0);
    wait_idle();

    // Partial strobes are refused without an SREG cycle
    exp_wr(18'h00024, 32'hCAFE_0001, 4'h3);
    drive_write(18'h00024, 32'hCAFE_0001, 4'h3, 1'b1, 1);
    wait_idle();
    exp_wr(18'h00024, 32'hCAFE_0002, 4'hE);
    drive_write(18'h00024, 32'hCAFE_0002, 4'hE, 1'b0, 0);
    wait_idle();
    exp_rd(18'h00024, 32'hA500_0024, 1'b1);
    drive_read(18'h00024, 1'b0);
    wait_idle();

    // Write response back-pressure with a read queued behind it
    s_bready = 1'b0;
    exp_wr(18'h00030, 32'hDEAD_BEEF, 4'hF);
    exp_rd(18'h0003C, 32'hA500_003C, 1'b1);
    drive_write(18'h00030, 32'hDEAD_BEEF, 4'hF, 1'b0, 0);
    drive_read(18'h0003C, 1'b0);
    for (int i = 0; i < 20 && !s_bvalid; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_bvalid_bresp", {s_bvalid, s_bresp}, 3'b100);
      check("bp_no_sreg_en", sreg_en, 0);
    end
    s_bready = 1'b1;
    wait_idle();

    // Reset during RD_WAIT: outputs clear at once, no response afterwards
    exp_rd(18'h00038, 32'h0, 1'b0);
    drive_read(18'h00038, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst_in_rd_wait", all_outs(), 0);
    release_reset();
    repeat (8) @(negedge clk);
    check("no_rvalid_after_rst", {s_rvalid, s_bvalid}, 0);

    // Reset while the read strobe is high: the strobe drops asynchronously
    drive_read(18'h00034, 1'b0);
    @(posedge clk); #1;
    check("rd_issue_before_rst", sreg_en, 1);
    rst = 1'b1;
    #1;
    check("rst_drops_sreg_en", sreg_en, 0);
    release_reset();
    repeat (6) @(negedge clk);

    // Simultaneous write and read, repeated: round-robin W,R,W,R...
    for (int k = 0; k < 4; k++) begin
      exp_wr(18'h00040 + 18'(8 * k), 32'h1111_0000 + 32'(k), 4'hF);
      exp_rd(18'h00080 + 18'(4 * k), 32'hA500_0080 + 32'(4 * k), 1'b1);
      fork
        drive_write(18'h00040 + 18'(8 * k), 32'h1111_0000 + 32'(k), 4'hF, 1'b0, 0);
        drive_read(18'h00080 + 18'(4 * k), 1'b0);
      join
      wait_idle();
    end

    check("queues_empty", {32'(q_sreg.size()), 16'(q_b.size()), 16'(q_r.size())}, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
